pc_seq_ctrl: RTL and testbench

- Program-counter sequencer for the PIC10F200 core.
- Owns the 9-bit PC register and the 2-level hardware call stack.
- Drives the PC mux select and the stack bus, and consumes the mux output for RETLW and PCL writes.
- Inserts the one-cycle pipeline flush required after every taken change of flow or skip.

---
 rtl/pic_pkg.sv | 9 +
 rtl/hw_stack.sv | 58 +++++
 rtl/pc_seq_ctrl.sv | 87 ++++++++
 tb/tb_pc_seq_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared PC sequencer types and constants for the PIC10F200 core
package pic_pkg;
  localparam int              PC_W         = 9;
  localparam int              STACK_DEPTH  = 2;
  localparam logic [PC_W-1:0] RESET_VECTOR = 9'h0FF;

  typedef enum logic {RUN, FLUSH} pcseq_state_t;
  typedef logic [8:0] pc_t;
endpackage

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - shift-register call stack with optional occupancy/error tracking
// Optional feature macro: STACK_ERR_EN (occupancy counter and sticky {overflow, underflow} flags)
module hw_stack #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic [1:0]   err
);
  logic [W-1:0] lvl [DEPTH];

  // Pop leaves the bottom level in place, so an empty stack keeps returning it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lvl[i] <= '0;
    end else if (en) begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) lvl[i] <= lvl[i+1];
      end else if (push) begin
        for (int i = DEPTH - 1; i > 0; i--) lvl[i] <= lvl[i-1];
        lvl[0] <= push_data;
      end
    end
  end

  assign top = lvl[0];

`ifdef STACK_ERR_EN
  localparam logic [1:0] FULL = 2'(DEPTH);
  logic [1:0] cnt;
  logic [1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= 2'd0;
      err_q <= 2'b00;
    end else if (en) begin
      if (pop) begin
        if (cnt == 2'd0) err_q[0] <= 1'b1;
        else             cnt      <= cnt - 2'd1;
      end else if (push) begin
        if (cnt == FULL) err_q[1] <= 1'b1;
        else             cnt      <= cnt + 2'd1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 2'b00;
`endif
endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - PC register, call stack and change-of-flow flush sequencer
// Optional feature macro: STACK_ERR_EN (stack_err reports sticky overflow/underflow)
module pc_seq_ctrl
  import pic_pkg::*;
#(
  parameter int              PC_W         = pic_pkg::PC_W,
  parameter int              STACK_DEPTH  = pic_pkg::STACK_DEPTH,
  parameter logic [PC_W-1:0] RESET_VECTOR = pic_pkg::RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            op_goto,
  input  logic            op_call,
  input  logic            op_retlw,
  input  logic            op_pcl_wr,
  input  logic            skip_taken,
  input  logic [PC_W-1:0] k_lit,
  input  logic [PC_W-1:0] pc_mux_in,
  output logic            pc_mux_sel,
  output logic [PC_W-1:0] stack_bus,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic [1:0]      stack_err
);
  pcseq_state_t    state, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic            push, pop;

  assign pc_inc = pc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      pc_q  <= RESET_VECTOR;
    end else if (en) begin
      state <= state_d;
      pc_q  <= pc_d;
    end
  end

  // Single-winner priority: retlw > call > goto > pcl_wr > skip > increment.
  always_comb begin
    state_d    = state;
    pc_d       = pc_inc;
    push       = 1'b0;
    pop        = 1'b0;
    pc_mux_sel = 1'b0;
    if (state == FLUSH) begin
      state_d = RUN;
    end else if (op_retlw) begin
      pc_d    = pc_mux_in;
      pop     = 1'b1;
      state_d = FLUSH;
    end else if (op_call) begin
      pc_d    = PC_W'(k_lit[7:0]);
      push    = 1'b1;
      state_d = FLUSH;
    end else if (op_goto) begin
      pc_d    = k_lit;
      state_d = FLUSH;
    end else if (op_pcl_wr) begin
      pc_d       = pc_mux_in;
      pc_mux_sel = 1'b1;
      state_d    = FLUSH;
    end else if (skip_taken) begin
      state_d = FLUSH;
    end
  end

  hw_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_bus),
    .err       (stack_err)
  );

  assign pc    = pc_q;
  assign flush = (state == FLUSH);
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, en;
  logic       op_goto, op_call, op_retlw, op_pcl_wr, skip_taken;
  logic [8:0] k_lit, pc_mux_in;
  logic       pc_mux_sel, flush;
  logic [8:0] stack_bus, pc;
  logic [1:0] stack_err;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef STACK_ERR_EN
  localparam logic [1:0] ERR_UF = 2'b01;
  localparam logic [1:0] ERR_OF = 2'b10;
`else
  localparam logic [1:0] ERR_UF = 2'b00;
  localparam logic [1:0] ERR_OF = 2'b00;
`endif

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .op_goto    (op_goto),
    .op_call    (op_call),
    .op_retlw   (op_retlw),
    .op_pcl_wr  (op_pcl_wr),
    .skip_taken (skip_taken),
    .k_lit      (k_lit),
    .pc_mux_in  (pc_mux_in),
    .pc_mux_sel (pc_mux_sel),
    .stack_bus  (stack_bus),
    .pc         (pc),
    .flush      (flush),
    .stack_err  (stack_err)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ops();
    op_goto = 0; op_call = 0; op_retlw = 0; op_pcl_wr = 0; skip_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; en = 1; clear_ops();
    step();
    rst_n = 1;
  endtask

  // GOTO x-1 then let the flush cycle increment to land in RUN at x.
  task automatic set_pc(input logic [8:0] x);
    clear_ops(); op_goto = 1; k_lit = x - 9'd1;
    step();
    clear_ops();
    step();
  endtask

  task automatic call_to(input logic [8:0] k);
    clear_ops(); op_call = 1; k_lit = k;
    step();
    clear_ops();
  endtask

  task automatic retlw_loop();
    clear_ops(); op_retlw = 1; pc_mux_in = stack_bus;
    step();
    clear_ops();
  endtask

  initial begin
    k_lit = 0; pc_mux_in = 0;
    rst_n = 0; en = 1; clear_ops();
    step(); step();
    rst_n = 1;
    check("rst_pc", 16'(pc), 16'h0FF);
    check("rst_flush", 16'(flush), 16'h0);
    check("rst_stack", 16'(stack_bus), 16'h000);
    check("rst_err", 16'(stack_err), 16'h0);
    check("rst_sel", 16'(pc_mux_sel), 16'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check("idle_pc", 16'(pc), 16'(9'h0FF + 9'(i)));
      check("idle_flush", 16'(flush), 16'h0);
    end

    // CALL, with a GOTO held during the flush that must be ignored
    set_pc(9'h020);
    check("setpc", 16'(pc), 16'h020);
    clear_ops(); op_call = 1; k_lit = 9'h1A5;
    step();
    check("call_pc", 16'(pc), 16'h0A5);
    check("call_stack", 16'(stack_bus), 16'h021);
    check("call_flush", 16'(flush), 16'h1);
    clear_ops(); op_goto = 1; k_lit = 9'h155;
    step();
    clear_ops();
    check("call_post_pc", 16'(pc), 16'h0A6);
    check("call_post_flush", 16'(flush), 16'h0);

    // Nested calls and returns, then underflow
    do_reset();
    set_pc(9'h010);
    call_to(9'h04F);
    step();
    check("nest_pc1", 16'(pc), 16'h050);
    call_to(9'h0C0);
    check("nest_pc2", 16'(pc), 16'h0C0);
    check("nest_top", 16'(stack_bus), 16'h051);
    step();
    retlw_loop();
    check("ret1_pc", 16'(pc), 16'h051);
    check("ret1_top", 16'(stack_bus), 16'h011);
    check("ret1_flush", 16'(flush), 16'h1);
    step();
    check("ret1_post", 16'(pc), 16'h052);
    retlw_loop();
    check("ret2_pc", 16'(pc), 16'h011);
    check("ret2_err", 16'(stack_err), 16'h0);
    step();
    retlw_loop();
    check("ret3_pc", 16'(pc), 16'h011);
    check("uf_err", 16'(stack_err), 16'(ERR_UF));
    step();

    // Overflow: the first return address 0x002 is lost
    do_reset();
    set_pc(9'h001);
    call_to(9'h001); step();
    call_to(9'h002); step();
    call_to(9'h003);
    check("of_top", 16'(stack_bus), 16'h004);
    check("of_err", 16'(stack_err), 16'(ERR_OF));
    step();
    retlw_loop();
    check("of_ret1", 16'(pc), 16'h004);
    step();
    retlw_loop();
    check("of_ret2", 16'(pc), 16'h003);
    check("of_err2", 16'(stack_err), 16'(ERR_OF));
    step();

    // GOTO beats PCL write; then PCL write alone
    do_reset();
    clear_ops(); op_pcl_wr = 1; op_goto = 1; k_lit = 9'h123; pc_mux_in = 9'h077;
    #1;
    check("prio_sel", 16'(pc_mux_sel), 16'h0);
    step();
    check("prio_pc", 16'(pc), 16'h123);
    clear_ops(); op_pcl_wr = 1;
    #1;
    check("flush_sel", 16'(pc_mux_sel), 16'h0);
    step();
    check("prio_post", 16'(pc), 16'h124);
    check("pcl_sel", 16'(pc_mux_sel), 16'h1);
    step();
    clear_ops();
    check("pcl_pc", 16'(pc), 16'h077);
    check("pcl_flush", 16'(flush), 16'h1);
    step();
    check("pcl_post", 16'(pc), 16'h078);

    // Increment and pushed return address both wrap
    set_pc(9'h1FF);
    step();
    check("wrap_pc", 16'(pc), 16'h000);
    set_pc(9'h1FF);
    call_to(9'h0AB);
    check("callwrap_pc", 16'(pc), 16'h0AB);
    check("callwrap_top", 16'(stack_bus), 16'h000);
    step();

    // Skip with en held low during the flush
    set_pc(9'h030);
    skip_taken = 1;
    step();
    clear_ops();
    check("skip_pc", 16'(pc), 16'h031);
    check("skip_flush", 16'(flush), 16'h1);
    en = 0;
    step(); step();
    check("hold_pc", 16'(pc), 16'h031);
    check("hold_flush", 16'(flush), 16'h1);
    en = 1;
    step();
    check("skip_post_pc", 16'(pc), 16'h032);
    check("skip_post_flush", 16'(flush), 16'h0);

    // Reset during FLUSH
    clear_ops(); op_goto = 1; k_lit = 9'h040;
    step();
    clear_ops();
    check("rf_flush", 16'(flush), 16'h1);
    rst_n = 0;
    step();
    rst_n = 1;
    check("rf_pc", 16'(pc), 16'h0FF);
    check("rf_flush0", 16'(flush), 16'h0);
    step();
    check("rf_post", 16'(pc), 16'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
